ysyx_22051013_axi_rd_arbiter: RTL
=================================

YSYX_22051013_AXI_RD_ARBITER -- requirements
Module: ysyx_22051013_axi_rd_arbiter

Interface
REQ-001 No parameters; address width 64, data width 64, resp width 2, fixed.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 ifu_ar_addr  input  64  IFU read address.
REQ-005 ifu_ar_valid  input  1  IFU read request.
REQ-006 ifu_ar_ready  output  1  IFU address accepted.
REQ-007 ifu_r_data  output  64  IFU read data.
REQ-008 ifu_r_resp  output  2  IFU read response.
REQ-009 ifu_r_valid  output  1  IFU read data valid.
REQ-010 ifu_r_ready  input  1  IFU can take data.
REQ-011 lsu_ar_addr, lsu_ar_valid, lsu_ar_ready, lsu_r_data, lsu_r_resp, lsu_r_valid, lsu_r_ready SHALL mirror REQ-004..010 for the LSU, same widths and directions.
REQ-012 m_ar_addr  output  64  shared AXI read address.
REQ-013 m_ar_valid  output  1  shared address valid.
REQ-014 m_ar_ready  input  1  slave address ready.
REQ-015 m_r_data  input  64  slave read data.
REQ-016 m_r_resp  input  2  slave read response.
REQ-017 m_r_valid  input  1  slave data valid.
REQ-018 m_r_ready  output  1  shared data ready.

Function
REQ-019 FSM states: IDLE, ADDR, DATA; owner register (0=IFU, 1=LSU); one outstanding single-beat transaction max.
REQ-020 IDLE: any ar_valid high -> latch winner into owner, go to ADDR next cycle; no valid -> stay IDLE.
REQ-021 IDLE: m_ar_valid=0, m_r_ready=0, both requester ar_ready=0 and r_valid=0.
REQ-022 ADDR: m_ar_addr/m_ar_valid = owner's ar_addr/ar_valid (combinational); owner ar_ready = m_ar_ready; m_ar_valid&m_ar_ready -> DATA.
REQ-023 DATA: m_ar_valid=0; m_r_ready = owner r_ready; owner r_data/r_resp/r_valid = m_r_*; m_r_valid&m_r_ready -> IDLE.
REQ-024 Non-owner: ar_ready=0, r_valid=0, r_data=0, r_resp=0 in all states.
REQ-025 m_ar_addr SHALL be 0 whenever not in ADDR.
REQ-026 Non-zero m_r_resp passed through unchanged; transaction still completes and FSM returns to IDLE.
REQ-027 Simultaneous IFU and LSU valid in IDLE: LSU wins (default arbitration).
REQ-028 Request arriving while another owns the bus waits; its ar_ready stays 0 until granted.
REQ-029 Minimum transaction length 3 cycles (IDLE, ADDR, DATA) with slave ready/valid immediate; no IDLE bypass.
REQ-030 Owner dropping ar_valid in ADDR: m_ar_valid follows low, FSM stays ADDR.

Reset
REQ-031 rst high at clock edge -> state IDLE, owner 0, round-robin history (if built) = IFU, regardless of current state.
REQ-032 Reset mid-transaction abandons it; any later m_r_valid is not forwarded and not acknowledged (m_r_ready=0 in IDLE).
REQ-033 All outputs take the REQ-021/REQ-024/REQ-025 values during and immediately after reset.

Configuration
REQ-034 Macro YSYX_22051013_ARB_RR_EN defined: round-robin on simultaneous requests, winner is requester not granted last; history register updated on each grant, reset value IFU (first tie -> LSU).
REQ-035 Macro undefined: fixed priority LSU over IFU, no history register; all other behaviour identical.

Verification
REQ-036 IFU only, addr 0x80000000, m_ar_ready=1, m_r_valid=1 data 0x0000000100000013 next cycle -> ifu_r_data matches, ifu_r_valid one cycle, lsu outputs 0.
REQ-037 IFU and LSU valid same cycle, addrs 0x80000000/0x80001000 -> m_ar_addr 0x80001000 first, then 0x80000000 after LSU completes; with RR_EN, second simultaneous tie grants IFU.
REQ-038 m_ar_ready held low 4 cycles -> FSM stays ADDR, m_ar_addr stable, ifu_ar_ready=0 until ready rises.
REQ-039 m_r_resp=2'b10 on LSU read -> lsu_r_resp=2'b10, FSM returns IDLE, next request served.
REQ-040 rst asserted in DATA, then m_r_valid=1 -> no r_valid to either requester, m_r_ready=0, state IDLE.

Source files
------------

// File: rtl/ysyx_22051013_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_axi_rd_arbiter
// Arbitrates two AXI read requesters (IFU, LSU) onto one shared AXI read
// master port. Only one single-beat transaction is outstanding at a time.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   ifu_ar_* / ifu_r_*  : IFU read address / read data channels (slave side)
//   lsu_ar_* / lsu_r_*  : LSU read address / read data channels (slave side)
//   m_ar_* / m_r_*      : shared read address / read data channels (master)
//
// Build option
//   YSYX_22051013_ARB_RR_EN : round-robin on simultaneous requests (winner is
//                             the requester not granted last). When undefined,
//                             LSU has fixed priority over IFU.
//
// state | meaning
// IDLE  | no transaction, waiting for any ar_valid
// ADDR  | owner's address presented on m_ar_*
// DATA  | waiting for the single read beat, forwarded to the owner
// ---------------------------------------------------------------------------
module ysyx_22051013_axi_rd_arbiter (
  input  logic        clk,
  input  logic        rst,
  // IFU
  input  logic [63:0] ifu_ar_addr,
  input  logic        ifu_ar_valid,
  output logic        ifu_ar_ready,
  output logic [63:0] ifu_r_data,
  output logic [1:0]  ifu_r_resp,
  output logic        ifu_r_valid,
  input  logic        ifu_r_ready,
  // LSU
  input  logic [63:0] lsu_ar_addr,
  input  logic        lsu_ar_valid,
  output logic        lsu_ar_ready,
  output logic [63:0] lsu_r_data,
  output logic [1:0]  lsu_r_resp,
  output logic        lsu_r_valid,
  input  logic        lsu_r_ready,
  // shared master
  output logic [63:0] m_ar_addr,
  output logic        m_ar_valid,
  input  logic        m_ar_ready,
  input  logic [63:0] m_r_data,
  input  logic [1:0]  m_r_resp,
  input  logic        m_r_valid,
  output logic        m_r_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   winner;

  logic        own_ar_valid;
  logic [63:0] own_ar_addr;
  logic        own_r_ready;

  assign own_ar_valid = (owner_q == OWN_LSU) ? lsu_ar_valid : ifu_ar_valid;
  assign own_ar_addr  = (owner_q == OWN_LSU) ? lsu_ar_addr  : ifu_ar_addr;
  assign own_r_ready  = (owner_q == OWN_LSU) ? lsu_r_ready  : ifu_r_ready;

`ifdef YSYX_22051013_ARB_RR_EN
  // last_q remembers the most recent grant; a tie goes to the other side.
  logic last_q, last_d;

  always_comb begin
    if (ifu_ar_valid && lsu_ar_valid) winner = ~last_q;
    else                              winner = lsu_ar_valid;
  end
`else
  always_comb begin
    winner = lsu_ar_valid;
  end
`endif

  // next state
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
`ifdef YSYX_22051013_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (ifu_ar_valid || lsu_ar_valid) begin
          state_d = ADDR;
          owner_d = winner;
`ifdef YSYX_22051013_ARB_RR_EN
          last_d  = winner;
`endif
        end
      end
      ADDR: begin
        if (own_ar_valid && m_ar_ready) state_d = DATA;
      end
      DATA: begin
        if (m_r_valid && own_r_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs; forced to idle values while rst is high so the abandoned
  // transaction is never visible, even in the cycle reset is applied
  always_comb begin
    m_ar_addr    = '0;
    m_ar_valid   = 1'b0;
    m_r_ready    = 1'b0;
    ifu_ar_ready = 1'b0;
    ifu_r_data   = '0;
    ifu_r_resp   = '0;
    ifu_r_valid  = 1'b0;
    lsu_ar_ready = 1'b0;
    lsu_r_data   = '0;
    lsu_r_resp   = '0;
    lsu_r_valid  = 1'b0;
    if (!rst) begin
      case (state_q)
        ADDR: begin
          m_ar_addr  = own_ar_addr;
          m_ar_valid = own_ar_valid;
          if (owner_q == OWN_LSU) lsu_ar_ready = m_ar_ready;
          else                    ifu_ar_ready = m_ar_ready;
        end
        DATA: begin
          m_r_ready = own_r_ready;
          if (owner_q == OWN_LSU) begin
            lsu_r_data  = m_r_data;
            lsu_r_resp  = m_r_resp;
            lsu_r_valid = m_r_valid;
          end else begin
            ifu_r_data  = m_r_data;
            ifu_r_resp  = m_r_resp;
            ifu_r_valid = m_r_valid;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IFU;
`ifdef YSYX_22051013_ARB_RR_EN
      last_q  <= OWN_IFU;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifdef YSYX_22051013_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule
